// File: rtl/complete_arbiter.sv
// In-order per-FU result FIFO with synchronous clear; head is visible combinationally.
// Latency: a push at edge N is at the head in cycle N+1.
// Backpressure: the caller gates push with count < DEPTH. This FIFO never pops when empty.
module complete_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 38
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic [W-1:0]                 push_dat,
    input  logic                         pop,
    output logic [W-1:0]                 head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !clear) mem[tail] <= push_dat;
    end

    assign head_dat = mem[head];
endmodule

// Complete stage: buffers FU results per source and round-robins them onto the PRF write port / CDB.
// Latency: a result accepted at edge N drives write_en in cycle N+2 when it faces no contention.
// Backpressure: fu_ready[i] depends only on FIFO occupancy. A result offered while not ready is dropped.
module complete_arbiter #(
    parameter int NUM_FU = 4,
    parameter int DEPTH  = 2,
    parameter int XLEN   = 32,
    parameter int TAG_W  = 6
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [NUM_FU-1:0]       fu_valid,
    input  logic [NUM_FU*TAG_W-1:0] fu_tag,
    input  logic [NUM_FU*XLEN-1:0]  fu_data,
    output logic [NUM_FU-1:0]       fu_ready,
    output logic                    write_en,
    output logic [TAG_W-1:0]        write_tag,
    output logic [XLEN-1:0]         write_data,
    output logic                    busy
);
    localparam int IW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  dat;
    } result_t;

    result_t           head  [NUM_FU];
    logic [CW-1:0]     count [NUM_FU];
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    logic [NUM_FU-1:0] nonempty;
    logic              grant_any;
    logic [IW-1:0]     grant_idx;
    logic [IW-1:0]     rr_ptr;
    int                scan;
    result_t           win;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        result_t in_res;

        assign in_res      = {fu_tag[i*TAG_W +: TAG_W], fu_data[i*XLEN +: XLEN]};
        assign fu_ready[i] = count[i] < CW'(DEPTH);
        assign nonempty[i] = count[i] != '0;
        // Tag 0 has no destination: the handshake completes but nothing is stored.
        assign push[i]     = fu_valid[i] && fu_ready[i] && !flush
                             && (fu_tag[i*TAG_W +: TAG_W] != '0);
        assign pop[i]      = grant_any && (grant_idx == IW'(i)) && !flush;

        complete_fifo #(.DEPTH(DEPTH), .W($bits(result_t))) u_fifo (
            .clock    (clock),
            .reset    (reset),
            .clear    (flush),
            .push     (push[i]),
            .push_dat (in_res),
            .pop      (pop[i]),
            .head_dat (head[i]),
            .count    (count[i])
        );
    end

    // First non-empty FIFO at or after rr_ptr, wrapping around, wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan      = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            scan = int'(rr_ptr) + k;
            if (scan >= NUM_FU) scan = scan - NUM_FU;
            if (!grant_any && nonempty[IW'(scan)]) begin
                grant_any = 1'b1;
                grant_idx = IW'(scan);
            end
        end
    end

    assign win = head[grant_idx];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            write_en   <= 1'b0;
            write_tag  <= '0;
            write_data <= '0;
            rr_ptr     <= '0;
        end else if (flush) begin
            // The squash keeps rr_ptr so that fairness continues across it.
            write_en <= 1'b0;
        end else begin
            write_en <= grant_any;
            if (grant_any) begin
                write_tag  <= win.tag;
                write_data <= win.dat;
                rr_ptr     <= (grant_idx == IW'(NUM_FU-1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    assign busy = (|nonempty) || write_en;
endmodule

// File: doc/complete_arbiter.md
Name: complete_arbiter

Overview:
- Complete stage directly upstream of the physical register file (PRF).
- Collects results from NUM_FU functional units and buffers them in per-FU FIFOs.
- Round-robin arbitrates the buffered results onto the single PRF write port.
- Drives the PRF write packet and the CDB tag broadcast from one registered output, at one result per cycle.

Parameters:
NUM_FU, 4, number of functional-unit result sources
DEPTH, 2, entries per FU result FIFO (power of 2, >=2)
XLEN, 32, result data width
TAG_W, 6, physical register tag width (64 physical registers)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
flush  in  1  synchronous squash (branch mispredict/exception)
fu_valid  in  NUM_FU  per-FU result valid
fu_tag  in  NUM_FU*TAG_W  per-FU destination physical tag
fu_data  in  NUM_FU*XLEN  per-FU result data
fu_ready  out  NUM_FU  per-FU FIFO can accept this cycle
write_en  out  1  PRF write enable / CDB valid
write_tag  out  TAG_W  PRF write tag / CDB broadcast tag
write_data  out  XLEN  PRF write data
busy  out  1  any FIFO non-empty or write_en high

Behaviour:
- Reset (reset==0, asynchronous):
  - all FIFOs are emptied: head/tail/count = 0.
  - write_en=0, write_tag=0, write_data=0.
  - rr_ptr=0.
  - fu_ready = all ones once reset deasserts.
- Accept:
  - fu_ready[i] = (count[i] < DEPTH), combinational from count only; there is no same-cycle pop credit.
  - Push on fu_valid[i] && fu_ready[i] at the rising edge.
  - fu_valid with fu_ready low is a protocol violation. The producer must hold the result until ready; the arbiter drops it.
- Tag 0:
  - A handshake with fu_tag[i]==0 (no destination) completes normally.
  - It is not enqueued and never produces write_en.
- Arbitration:
  - Combinational over the FIFO heads. Candidates = FIFOs with count>0.
  - Scan starts at rr_ptr, wraps modulo NUM_FU; the first candidate wins.
  - The winner's head is popped at the edge and loaded into the output register.
- Output register:
  - Each edge: write_en <= grant_any; if grant_any, write_tag/write_data <= winner head.
  - write_tag/write_data hold their last value when write_en=0.
- rr_ptr: on a grant to FU i, rr_ptr <= (i+1) mod NUM_FU; with no grant it is unchanged.
- Latency:
  - A result accepted at edge N (fu_valid high in cycle N) is at the FIFO head in cycle N+1.
  - With no contention it gives write_en=1 in cycle N+2; the PRF commits at the end of N+2.
- Throughput: one write per cycle; FIFOs drain in round-robin order.
- FIFO: in-order per FU. Simultaneous push+pop on the same FIFO leaves count unchanged, and head/tail wrap modulo DEPTH.
- Flush (synchronous, overrides all):
  - At the edge: all counts/pointers <= 0, write_en <= 0, and inputs that cycle are not accepted.
  - rr_ptr is preserved.
  - write_en is 0 in the cycle after flush.
- busy = (|count) || write_en, combinational.
- Asynchronous reset asserted mid-operation discards all buffered results immediately. No partial write_en pulse is allowed after reset asserts.

Test Plan:
1. Reset low 3 cycles, then release → write_en=0, write_tag=0, fu_ready=4'b1111, busy=0.
2. Single result: FU2 valid, tag=5, data=0xDEADBEEF in cycle 0 → write_en=1, write_tag=5, write_data=0xDEADBEEF in cycle 2 only; busy=0 by cycle 3.
3. Contention: all 4 FUs valid in cycle 0 with tags 1,2,3,4 and rr_ptr=0 → write_tag sequence 1,2,3,4 in cycles 2..5 with write_en=1 each cycle. Then a second burst with tags 9..12 from FUs 0..3 yields 9,10,11,12, confirming fairness and wrap.
4. Backpressure: hold FU0 valid every cycle while FUs 1–3 also stream.
   - fu_ready[0] drops when count[0]=2.
   - No FU0 result is lost or reordered: its tags 10,11,12,13 appear in order on write_tag.
5. Tag 0: FU1 valid with tag=0 → handshake completes, no write_en ever, busy stays 0.
6. Flush: 4 results buffered, assert flush for 1 cycle, with FU3 also valid that cycle → write_en=0 the next cycle, busy=0, FU3 result never appears. rr_ptr is unchanged on the next grant. Separately, asserting reset mid-drain forces write_en=0 asynchronously.
